// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES input block packer.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BYTE_BITS   = 8;
  localparam int AES_BLOCK_BITS  = AES_BLOCK_BYTES * AES_BYTE_BITS;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

endpackage

// File: rtl/flex_full_counter.sv
// Free-running up counter with synchronous clear; wraps at its full width.
module flex_full_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_out = r_count;

endmodule

// File: rtl/aes_block_packer.sv
// Packs show-ahead FIFO bytes into 128-bit AES blocks; flush zero-pads and tags the final block.
// Block handshake: block_valid stays high with block_data/last/pad_len stable until the cycle block_ready is also high.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter  int NUMBITS    = AES_BYTE_BITS,
  parameter  int BLOCKBYTES = AES_BLOCK_BYTES,
  localparam int PADW       = $clog2(BLOCKBYTES) + 1,
  localparam int IDXW       = $clog2(BLOCKBYTES)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          fifo_empty,
  input  logic [NUMBITS-1:0]            fifo_r_data,
  output logic                          fifo_r_enable,
  input  logic                          flush,
  output logic [NUMBITS*BLOCKBYTES-1:0] block_data,
  output logic                          block_valid,
  input  logic                          block_ready,
  output logic                          block_last,
  output logic [PADW-1:0]               pad_len,
  output logic [15:0]                   blk_count,
  output packer_state_t                 dbg_state
);

  packer_state_t                 r_state;
  packer_state_t                 w_next_state;
  logic [IDXW-1:0]               w_byte_idx;
  logic                          w_pop;
  logic                          w_last_byte;
  logic                          w_flush_go;
  logic                          w_handoff;
  logic [PADW-1:0]               w_pad_fill;
  logic [NUMBITS*BLOCKBYTES-1:0] r_block_data;
  logic                          r_block_valid;
  logic                          r_block_last;
  logic [PADW-1:0]               r_pad_len;
  logic [15:0]                   r_blk_count;
  logic                          r_flush_pending;

  flex_full_counter #(
    .NUM_CNT_BITS (IDXW)
  ) u_byte_idx (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_handoff),
    .count_enable (w_pop),
    .count_out    (w_byte_idx)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      FILL:    if (w_last_byte || w_flush_go) w_next_state = HOLD;
      HOLD:    if (block_ready) w_next_state = FILL;
      default: w_next_state = FILL;
    endcase
  end

  always_comb begin
    w_pop      = 1'b0;
    w_flush_go = 1'b0;
    w_handoff  = 1'b0;
    unique case (r_state)
      FILL: begin
        w_pop      = !fifo_empty;
        w_flush_go = fifo_empty && r_flush_pending;
      end
      HOLD:    w_handoff = block_ready;
      default: w_pop     = 1'b0;
    endcase
  end

  assign w_last_byte = w_pop && (w_byte_idx == IDXW'(BLOCKBYTES - 1));
  assign w_pad_fill  = PADW'(BLOCKBYTES) - {1'b0, w_byte_idx};

  // Slots left unwritten stay zero because the block clears on every handoff.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_block_data <= '0;
    end else if (w_handoff) begin
      r_block_data <= '0;
    end else if (w_pop) begin
      for (int i = 0; i < BLOCKBYTES; i++) begin
        if (w_byte_idx == IDXW'(i)) begin
          r_block_data[(BLOCKBYTES-1-i)*NUMBITS +: NUMBITS] <= fifo_r_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_block_valid   <= 1'b0;
      r_block_last    <= 1'b0;
      r_pad_len       <= '0;
      r_blk_count     <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      r_block_valid <= (w_next_state == HOLD);
      if (w_flush_go) begin
        r_block_last <= 1'b1;
        r_pad_len    <= w_pad_fill;
      end else if (w_last_byte || w_handoff) begin
        r_block_last <= 1'b0;
        r_pad_len    <= '0;
      end
      // A flush seen while the flag is already set (or being consumed) is absorbed.
      if (w_flush_go) begin
        r_flush_pending <= 1'b0;
      end else if (flush) begin
        r_flush_pending <= 1'b1;
      end
      if (w_handoff) begin
        r_blk_count <= r_blk_count + 16'd1;
      end
    end
  end

  assign fifo_r_enable = w_pop;
  assign block_data    = r_block_data;
  assign block_valid   = r_block_valid;
  assign block_last    = r_block_last;
  assign pad_len       = r_pad_len;
  assign blk_count     = r_blk_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: FIFO model, scoreboard queue and handoff monitor.
module tb_aes_block_packer;
  import aes_pkg::*;

  localparam int EW = 128 + 1 + 5;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          fifo_empty = 1'b1;
  logic [7:0]    fifo_r_data = 8'h00;
  logic          fifo_r_enable;
  logic          flush;
  logic [127:0]  block_data;
  logic          block_valid;
  logic          block_ready;
  logic          block_last;
  logic [4:0]    pad_len;
  logic [15:0]   blk_count;
  packer_state_t dbg_state;

  logic [7:0]    fifo_q[$];
  logic [EW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            model_cnt = 0;

  aes_block_packer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .fifo_empty    (fifo_empty),
    .fifo_r_data   (fifo_r_data),
    .fifo_r_enable (fifo_r_enable),
    .flush         (flush),
    .block_data    (block_data),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .block_last    (block_last),
    .pad_len       (pad_len),
    .blk_count     (blk_count),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Show-ahead FIFO: pops sampled at the edge, head refreshed 2 time units later.
  always @(posedge clk) begin : fifo_model
    logic do_pop;
    do_pop = fifo_r_enable;
    #2;
    if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic [127:0] d, input logic l, input logic [4:0] p);
    return {d, l, p};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (n_rst && block_valid && block_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_block: got %h expected none", block_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("blk_data", block_data, e[EW-1:6]);
        check("blk_last", block_last, e[5]);
        check("blk_pad", pad_len, e[4:0]);
        check("blk_count_at_handoff", blk_count, model_cnt[15:0]);
        model_cnt++;
      end
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !block_valid) break;
    end
    if (i == 200) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d blocks pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    n_rst       = 1'b0;
    flush       = 1'b0;
    block_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", block_valid, 1'b0);
    check("rst_data", block_data, 128'h0);
    check("rst_last", block_last, 1'b0);
    check("rst_pad", pad_len, 5'd0);
    check("rst_count", blk_count, 16'd0);
    check("rst_state", 128'(dbg_state), 128'(FILL));
    @(posedge clk);
    #1 n_rst = 1'b1;

    // full block, timing of first valid
    block_ready = 1'b1;
    exp_q.push_back(mk_exp(128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 1'b0, 5'd0));
    push_bytes(8'h00, 16);
    @(negedge clk);
    check("t1_first_pop", fifo_r_enable, 1'b1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t1_valid_before_16", block_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_at_16", block_valid, 1'b1);
    wait_drain("t1");
    check("t1_blk_count", blk_count, 16'd1);

    // three bytes then flush
    exp_q.push_back(mk_exp(128'h1122_3300_0000_0000_0000_0000_0000_0000, 1'b1, 5'd13));
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_drain("t2");

    // 16 bytes with flush on the final write
    exp_q.push_back(mk_exp(128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF, 1'b0, 5'd0));
    exp_q.push_back(mk_exp(128'h0, 1'b1, 5'd16));
    push_bytes(8'hA0, 16);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_drain("t3");
    check("t3_blk_count", blk_count, 16'd4);

    // backpressure with 20 bytes queued
    block_ready = 1'b0;
    exp_q.push_back(mk_exp(128'h2021_2223_2425_2627_2829_2A2B_2C2D_2E2F, 1'b0, 5'd0));
    exp_q.push_back(mk_exp(128'h3031_3233_0000_0000_0000_0000_0000_0000, 1'b1, 5'd12));
    push_bytes(8'h20, 20);
    for (i = 0; i < 40 && !block_valid; i++) @(negedge clk);
    if (!block_valid) begin
      checks++;
      failures++;
      $display("FAIL t4_valid_timeout: got 0 expected 1");
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4_no_pop_in_hold", fifo_r_enable, 1'b0);
      check("t4_data_stable", block_data, 128'h2021_2223_2425_2627_2829_2A2B_2C2D_2E2F);
    end
    check("t4_fifo_left", 128'(fifo_q.size()), 128'd4);
    @(posedge clk);
    #1 block_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_valid_dropped", block_valid, 1'b0);
    check("t4_pop_after_handoff", fifo_r_enable, 1'b1);
    @(posedge clk);
    #1 flush = 1'b1;
    #2 check("t4_fifo_after_pop", 128'(fifo_q.size()), 128'd3);
    @(posedge clk);
    #1 flush = 1'b0;
    wait_drain("t4");

    // reset mid-block with flush pending
    push_bytes(8'h60, 9);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (6) @(posedge clk);
    #1 n_rst = 1'b0;
    fifo_q.delete();
    @(negedge clk);
    check("t5_rst_valid", block_valid, 1'b0);
    check("t5_rst_data", block_data, 128'h0);
    check("t5_rst_last", block_last, 1'b0);
    check("t5_rst_pad", pad_len, 5'd0);
    check("t5_rst_count", blk_count, 16'd0);
    check("t5_rst_state", 128'(dbg_state), 128'(FILL));
    @(posedge clk);
    #1 n_rst = 1'b1;
    model_cnt = 0;
    exp_q.push_back(mk_exp(128'h5051_5253_5455_5657_5859_5A5B_5C5D_5E5F, 1'b0, 5'd0));
    push_bytes(8'h50, 16);
    wait_drain("t5");
    repeat (5) @(negedge clk);
    check("t5_no_stale_flush", block_valid, 1'b0);
    check("t5_blk_count", blk_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
